// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard: scoreboard of in-flight destinations driving forwarding, load-use stalls, flushes and memory freeze
module mips_hazard_scoreboard #(
  parameter int RB = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W = 16,
  localparam int FW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RB-1:0]    id_rs,
  input  logic [RB-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr,
  input  logic [RB-1:0]    id_rd,
  input  logic             id_load,
  input  logic             id_mem,
  input  logic             id_jump,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic             hold_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [DEPTH-1:0] v, wr;
  logic [DEPTH-2:0] ld;
  logic [1:0] mm;
  logic [RB-1:0] rd [DEPTH];
  logic [RB-1:0] rs0, rt0;
  logic [DEPTH-1:1] ha, hb;
  logic [DEPTH-2:0] hs, ht;
  logic [FW-1:0] fa, fb;
  logic la, lb, luse, frz, brk, fwd_bad;
  always_comb begin
    ha = '0;
    hb = '0;
    hs = '0;
    ht = '0;
    fa = '0;
    fb = '0;
    la = 1'b0;
    lb = 1'b0;
    fwd_bad = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      ha[k] = v[k] & wr[k] & (rd[k] != '0) & (rd[k] == rs0);
      hb[k] = v[k] & wr[k] & (rd[k] != '0) & (rd[k] == rt0);
    end
    for (int k = 0; k < DEPTH-1; k++) begin
      hs[k] = v[k] & wr[k] & (rd[k] != '0) & (rd[k] == id_rs);
      ht[k] = v[k] & wr[k] & (rd[k] != '0) & (rd[k] == id_rt);
    end
    // scanning oldest to youngest lets the youngest producer overwrite
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (ha[k]) fa = FW'(k);
      if (hb[k]) fb = FW'(k);
    end
    for (int k = DEPTH-2; k >= 0; k--) begin
      if (hs[k]) la = ld[k] & (k + 1 < LOAD_AVAIL);
      if (ht[k]) lb = ld[k] & (k + 1 < LOAD_AVAIL);
    end
    fa = v[0] ? fa : '0;
    fb = v[0] ? fb : '0;
    for (int k = 1; k < DEPTH-1; k++)
      fwd_bad |= ((fa == FW'(k)) | (fb == FW'(k))) & ld[k] & (k < LOAD_AVAIL);
  end
  assign frz = v[1] & mm[1] & ~mem_ready;
  assign luse = id_valid & ((id_use_rs & la) | (id_use_rt & lb));
  assign brk = reset & ~frz & br_taken;
  assign fwd_a = fa;
  assign fwd_b = fb;
  assign freeze = frz;
  assign hold_if_id = frz | (luse & ~brk);
  assign flush_if_id = brk | (reset & ~frz & ~luse & id_valid & id_jump);
  assign flush_id_ex = brk | (~frz & luse);
  assign flush_ex_mem = brk;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v <= '0;
      wr <= '0;
      ld <= '0;
      mm <= '0;
      rs0 <= '0;
      rt0 <= '0;
      for (int k = 0; k < DEPTH; k++) rd[k] <= '0;
    end else if (!frz) begin
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        wr[k] <= wr[k-1];
        rd[k] <= rd[k-1];
      end
      for (int k = 1; k < DEPTH-1; k++) ld[k] <= ld[k-1];
      if (brk) v[1] <= 1'b0;
      mm[1] <= mm[0];
      v[0] <= id_valid & ~brk & ~luse;
      wr[0] <= id_wr & ~id_jump;
      rd[0] <= id_rd;
      ld[0] <= id_load;
      mm[0] <= id_mem;
      rs0 <= id_rs;
      rt0 <= id_rt;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((frz | luse) & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id & ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end
  a_no_early_load_fwd: assert property (@(posedge clk) disable iff (!reset) !fwd_bad);
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// tb_mips_hazard_scoreboard: directed and random stimulus against a queue-based pipeline model with a scoreboard monitor
module tb_mips_hazard_scoreboard;
  localparam int RB = 5, D = 4, LA = 3, CW = 4, FW = $clog2(D);
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b0;
  logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
  logic id_load = 1'b0, id_mem = 1'b0, id_jump = 1'b0, br_taken = 1'b0, mem_ready = 1'b1;
  logic [RB-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [FW-1:0] fwd_a, fwd_b;
  logic hold_if_id, flush_if_id, flush_id_ex, flush_ex_mem, freeze;
  logic [CW-1:0] stall_cnt, flush_cnt;
  mips_hazard_scoreboard #(.RB(RB), .DEPTH(D), .LOAD_AVAIL(LA), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
    .id_load(id_load), .id_mem(id_mem), .id_jump(id_jump), .br_taken(br_taken),
    .mem_ready(mem_ready), .fwd_a(fwd_a), .fwd_b(fwd_b), .hold_if_id(hold_if_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {bit v, wr, ld, mm; int rd, rs, rt;} ent_t;
  typedef struct {bit iv, urs, urt, wr, ld, mm, jp; int rs, rt, rd;} id_t;
  typedef struct {int fa, fb; bit hold, fif, fie, fem, frz; int sc, fc;} exp_t;
  ent_t pipe[$];
  exp_t q[$];
  int sc = 0, fc = 0, n_cmp = 0, n_bad = 0;
  bit last_hold = 1'b0;
  id_t cur;
  function automatic bit hit(ent_t e, int r);
    return e.v && e.wr && e.rd != 0 && e.rd == r;
  endfunction
  function automatic int src(int r);
    if (!pipe[0].v) return 0;
    for (int k = 1; k < D; k++) if (hit(pipe[k], r)) return k;
    return 0;
  endfunction
  function automatic bit stall_on(int r);
    for (int k = 0; k < D-1; k++) if (hit(pipe[k], r)) return pipe[k].ld && (k + 1 < LA);
    return 1'b0;
  endfunction
  function automatic id_t mk(bit iv, bit urs, bit urt, bit wr, bit ld, bit mm, bit jp, int rs, int rt, int rd);
    id_t i;
    i.iv = iv; i.urs = urs; i.urt = urt; i.wr = wr; i.ld = ld; i.mm = mm; i.jp = jp;
    i.rs = urs ? rs : 0; i.rt = urt ? rt : 0; i.rd = rd;
    return i;
  endfunction
  function automatic id_t alu(int d, int s, int t); return mk(1, 1, 1, 1, 0, 0, 0, s, t, d); endfunction
  function automatic id_t lw(int d, int s); return mk(1, 1, 0, 1, 1, 1, 0, s, 0, d); endfunction
  function automatic id_t sw(int s, int t); return mk(1, 1, 1, 0, 0, 1, 0, s, t, 0); endfunction
  function automatic id_t nop(); return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic id_t rand_id();
    int kind = $urandom_range(0, 9);
    bit us = 1'($urandom_range(0, 1)), ut = 1'($urandom_range(0, 1));
    int s = $urandom_range(0, 7), t = $urandom_range(0, 7), d = $urandom_range(0, 7);
    bit iv = $urandom_range(0, 9) != 0;
    if (kind < 3) return mk(iv, 1, 0, 1, 1, 1, 0, s, 0, d);
    if (kind == 3) return mk(iv, 1, 1, 0, 0, 1, 0, s, t, 0);
    if (kind == 4) return mk(iv, us, 0, 1'($urandom_range(0, 1)), 0, 0, 1, s, 0, d);
    return mk(iv, us, ut, 1, 0, 0, 0, s, t, d);
  endfunction
  task automatic step(id_t id, bit br, bit mr, bit rn);
    exp_t e;
    ent_t b, n, t;
    bit frz, lu;
    @(negedge clk);
    reset = rn; id_valid = id.iv; id_use_rs = id.urs; id_use_rt = id.urt; id_wr = id.wr;
    id_load = id.ld; id_mem = id.mm; id_jump = id.jp; br_taken = br; mem_ready = mr;
    id_rs = RB'(id.rs); id_rt = RB'(id.rt); id_rd = RB'(id.rd);
    #1;
    e = '{default: 0};
    b = '{default: 0};
    if (!rn) begin
      pipe = {};
      repeat (D) pipe.push_back(b);
      sc = 0;
      fc = 0;
    end else begin
      frz = pipe[1].v && pipe[1].mm && !mr;
      lu = id.iv && ((id.urs && stall_on(id.rs)) || (id.urt && stall_on(id.rt)));
      e.fa = src(pipe[0].rs);
      e.fb = src(pipe[0].rt);
      e.frz = frz;
      e.sc = sc;
      e.fc = fc;
      if (frz) e.hold = 1;
      else if (br) begin e.fif = 1; e.fie = 1; e.fem = 1; end
      else if (lu) begin e.hold = 1; e.fie = 1; end
      else if (id.iv && id.jp) e.fif = 1;
      if ((frz || lu) && sc < SAT) sc++;
      if (e.fif && fc < SAT) fc++;
      n = '{v: id.iv, wr: id.wr && !id.jp, ld: id.ld, mm: id.mm, rd: id.rd, rs: id.rs, rt: id.rt};
      if (!frz) begin
        if (br || lu) n = b;
        pipe.push_front(n);
        if (br) begin t = pipe[1]; t.v = 0; pipe[1] = t; end
        void'(pipe.pop_back());
      end
    end
    q.push_back(e);
    last_hold = e.hold;
  endtask
  task automatic go(id_t id, int cnt = 1, bit br = 0, bit mr = 1);
    repeat (cnt) step(id, br, mr, 1);
  endtask
  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, x);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_a", 32'(fwd_a), 32'(e.fa));
      chk("fwd_b", 32'(fwd_b), 32'(e.fb));
      chk("hold_if_id", 32'(hold_if_id), 32'(e.hold));
      chk("flush_if_id", 32'(flush_if_id), 32'(e.fif));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(e.fie));
      chk("flush_ex_mem", 32'(flush_ex_mem), 32'(e.fem));
      chk("freeze", 32'(freeze), 32'(e.frz));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
    end
  end
  initial begin
    step(nop(), 1, 0, 0);
    step(nop(), 0, 1, 0);
    go(alu(3, 1, 2)); go(alu(4, 3, 3)); go(alu(5, 3, 3)); go(nop(), 3);
    go(lw(5, 1)); go(alu(6, 5, 0), 3); go(nop(), 4);
    go(alu(7, 1, 1)); go(alu(7, 2, 2)); go(alu(8, 7, 0));
    go(alu(0, 1, 1)); go(alu(9, 0, 0)); go(nop(), 4);
    go(sw(1, 2)); go(nop()); go(nop(), 3, 0, 0); go(nop(), 3);
    go(lw(5, 1)); go(alu(6, 5, 5), 1, 1); go(nop(), 3);
    go(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 31)); go(nop(), 2);
    step(nop(), 1, 0, 0);
    go(sw(1, 2)); go(nop()); go(nop(), 20, 0, 0); go(nop(), 3);
    for (int i = 0; i < 3000; i++) begin
      if (!last_hold) cur = rand_id();
      step(cur, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
